sdram_burst_reader: RTL and testbench

//  Streaming read master for one arbiter port. Given a start word address and a

---
 rtl/sdram_pkg.sv | 32 +++
 rtl/sdram_core_if.sv | 34 +++
 rtl/sdram_sync_fifo.sv | 75 +++++++
 rtl/sdram_burst_reader.sv | 202 ++++++++++++++++++++
 tb/tb_sdram_burst_reader.sv | 378 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sdram_pkg
//  Purpose  : Shared types and helpers for the SDRAM burst read path.
//  Revision : 1.0  initial release
// ============================================================================
package sdram_pkg;

    // Burst reader control states
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WAIT = 3'd1,
        REQ  = 3'd2,
        DATA = 3'd3,
        DONE = 3'd4
    } rd_state_t;

    // Ceiling log2, usable in constant expressions (clog2(1) == 0)
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_core_if.sv
`default_nettype none
// ============================================================================
//  Module   : sdram_core_if
//  Purpose  : Request/response bundle between a port master and the SDRAM
//             arbiter/core. The manager holds rd/addr/len until accept, then
//             collects len words on ack; error ends the transaction.
//  Revision : 1.0  initial release
// ============================================================================
interface sdram_core_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 8
);
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] write_data;
    logic              accept;
    logic              ack;
    logic [DATA_W-1:0] read_data;
    logic              error;

    modport man (
        output rd, wr, addr, len, write_data,
        input  accept, ack, read_data, error
    );

    modport sub (
        input  rd, wr, addr, len, write_data,
        output accept, ack, read_data, error
    );
endinterface
`default_nettype wire

// File: rtl/sdram_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sdram_sync_fifo
//  Purpose  : Single-clock show-ahead FIFO. A simultaneous push and pop
//             always leaves the occupancy unchanged, also at full or empty.
//             The head reads as zero while the FIFO is empty.
//  Revision : 1.0  initial release
// ============================================================================
module sdram_sync_fifo
    import sdram_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic                          pop,
    input  logic [DATA_W-1:0]             din,
    output logic [DATA_W-1:0]             dout,
    output logic [clog2(FIFO_DEPTH):0]    count,
    output logic                          full,
    output logic                          empty
);

    localparam int PTR_W = clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] c_depth = OCC_W'(FIFO_DEPTH);

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wrPtr;
    logic [PTR_W-1:0]  r_rdPtr;
    logic [OCC_W-1:0]  r_count;
    logic              w_doPush;
    logic              w_doPop;

    // A pop frees the slot a same-cycle push needs, and vice versa
    assign w_doPush = push & (~full  | pop);
    assign w_doPop  = pop  & (~empty | push);

    assign full  = (r_count == c_depth);
    assign empty = (r_count == '0);
    assign count = r_count;
    assign dout  = empty ? '0 : r_mem[r_rdPtr];

    // Storage array, written on accepted push only
    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= din;
        end
    end

    // Pointers wrap naturally because the depth is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            if (w_doPush && !w_doPop) begin
                r_count <= r_count + OCC_W'(1);
            end else if (w_doPop && !w_doPush) begin
                r_count <= r_count - OCC_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sdram_burst_reader.sv
`default_nettype none
// ============================================================================
//  Module   : sdram_burst_reader
//  Purpose  : Streaming read master. Splits a word-count job into bursts of
//             at most BURST_LEN words, requests each only once the output
//             FIFO has room for the whole burst, and streams the returned
//             words out over valid/ready.
//  Revision : 1.0  initial release
// ============================================================================
module sdram_burst_reader
    import sdram_pkg::*;
#(
    parameter int ADDR_W     = 24,
    parameter int DATA_W     = 16,
    parameter int LEN_W      = 8,
    parameter int CNT_W      = 24,
    parameter int BURST_LEN  = 8,
    parameter int FIFO_DEPTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  total_words,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    sdram_core_if.man         core_if
);

    localparam int FIFO_CW = clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] c_burstMaxCnt = CNT_W'(BURST_LEN);
    localparam logic [LEN_W-1:0] c_burstMax    = LEN_W'(BURST_LEN);

    rd_state_t          r_state;
    rd_state_t          w_nextState;
    logic [ADDR_W-1:0]  r_curAddr;
    logic [CNT_W-1:0]   r_remaining;
    logic [LEN_W-1:0]   r_beat;
    logic               r_error;

    logic [LEN_W-1:0]   w_burst;
    logic [31:0]        w_free;
    logic               w_spaceOk;
    logic               w_lastBeat;
    logic [CNT_W-1:0]   w_remAfter;
    logic               w_push;
    logic               w_pop;
    logic [DATA_W-1:0]  w_fifoDout;
    logic [FIFO_CW-1:0] w_fifoCount;
    logic               w_fifoFull;
    logic               w_fifoEmpty;

    // Current burst size and the bookkeeping derived from it
    always_comb begin
        w_burst    = (r_remaining >= c_burstMaxCnt) ? c_burstMax : r_remaining[LEN_W-1:0];
        w_free     = 32'(FIFO_DEPTH) - 32'(w_fifoCount);
        w_spaceOk  = (w_free >= 32'(w_burst));
        w_lastBeat = (r_beat == (w_burst - LEN_W'(1)));
        w_remAfter = r_remaining - CNT_W'(w_burst);
    end

    // Only acked beats that are not error cycles enter the FIFO
    assign w_push  = (r_state == DATA) & core_if.ack & ~core_if.error;
    assign w_pop   = m_valid & m_ready;
    assign m_valid = ~w_fifoEmpty;
    assign m_data  = w_fifoDout;
    assign error   = r_error;

    sdram_sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (core_if.read_data),
        .dout  (w_fifoDout),
        .count (w_fifoCount),
        .full  (w_fifoFull),
        .empty (w_fifoEmpty)
    );

    // State register; reset forces IDLE immediately, which drops rd at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_nextState = (total_words == '0) ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (abort) begin
                    w_nextState = DONE;
                end else if (w_spaceOk) begin
                    w_nextState = REQ;
                end
            end
            REQ: begin
                // An accept in the same cycle as abort still commits the burst
                if (core_if.accept) begin
                    w_nextState = DATA;
                end else if (abort) begin
                    w_nextState = DONE;
                end
            end
            DATA: begin
                if (core_if.error) begin
                    w_nextState = DONE;
                end else if (core_if.ack && w_lastBeat) begin
                    w_nextState = ((w_remAfter == '0) || abort) ? DONE : WAIT;
                end
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Outputs decoded from the current state; this port never writes
    always_comb begin
        busy               = (r_state != IDLE);
        done               = (r_state == DONE);
        core_if.rd         = 1'b0;
        core_if.addr       = '0;
        core_if.len        = '0;
        core_if.wr         = 1'b0;
        core_if.write_data = '0;
        if (r_state == REQ) begin
            core_if.rd   = 1'b1;
            core_if.addr = r_curAddr;
            core_if.len  = w_burst;
        end
    end

    // Job address/length tracking, beat counter and sticky error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_curAddr   <= '0;
            r_remaining <= '0;
            r_beat      <= '0;
            r_error     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_curAddr   <= base_addr;
                        r_remaining <= total_words;
                        r_error     <= 1'b0;
                    end
                end
                REQ: begin
                    if (core_if.accept) begin
                        r_beat <= '0;
                    end
                end
                DATA: begin
                    if (core_if.error) begin
                        r_error <= 1'b1;
                    end else if (core_if.ack) begin
                        r_beat <= r_beat + LEN_W'(1);
                        if (w_lastBeat) begin
                            r_curAddr   <= r_curAddr + ADDR_W'(w_burst);
                            r_remaining <= w_remAfter;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    // Space is reserved before each request, so an ack must never hit a full FIFO
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(w_push && w_fifoFull && !w_pop));
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sdram_burst_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_sdram_burst_reader
//  Purpose  : Self-checking bench with a behavioural SDRAM core responder and
//             a job-level reference model (request list and word stream).
//  Revision : 1.0  initial release
// ============================================================================
module tb_sdram_burst_reader;

    localparam int ADDR_W     = 24;
    localparam int DATA_W     = 16;
    localparam int LEN_W      = 8;
    localparam int CNT_W      = 24;
    localparam int BURST_LEN  = 8;
    localparam int FIFO_DEPTH = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              m_ready = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [CNT_W-1:0]  total_words = '0;
    logic              busy;
    logic              done;
    logic              error;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;

    sdram_core_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) core_if ();

    sdram_burst_reader #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .LEN_W      (LEN_W),
        .CNT_W      (CNT_W),
        .BURST_LEN  (BURST_LEN),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .base_addr   (base_addr),
        .total_words (total_words),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .m_ready     (m_ready),
        .core_if     (core_if)
    );

    always #5 clk = ~clk;

    int nVec = 0;
    int nErr = 0;

    // Core responder controls
    int acceptDelay = 0;
    int errBeat     = -1;
    bit ackGaps     = 1'b0;

    // Observations
    logic [ADDR_W-1:0] gotAddr[$];
    int                gotLen[$];
    int                gotHeld[$];
    bit                gotStable[$];
    logic [DATA_W-1:0] gotData[$];
    int                doneCnt = 0;
    int                rdCycles = 0;

    // Reference model expectations
    logic [ADDR_W-1:0] expAddr[$];
    int                expLen[$];
    logic [DATA_W-1:0] expData[$];

    // Memory contents seen by the core: odd multiplier keeps neighbours distinct
    function automatic logic [DATA_W-1:0] memWord(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] h;
        h = a * 24'h009E37 + 24'h001234;
        return h[23:8];
    endfunction

    // Behavioural core: accepts after acceptDelay extra cycles, returns len words
    initial begin : p_core
        int held;
        int beat;
        bit stable;
        logic [ADDR_W-1:0] reqAddr;
        logic [LEN_W-1:0]  reqLen;
        held = 0;
        stable = 1'b1;
        reqAddr = '0;
        reqLen = '0;
        core_if.accept = 1'b0;
        core_if.ack = 1'b0;
        core_if.error = 1'b0;
        core_if.read_data = '0;
        forever begin
            @(negedge clk);
            core_if.accept = 1'b0;
            core_if.ack = 1'b0;
            core_if.error = 1'b0;
            if (rst || !core_if.rd) begin
                held = 0;
            end else begin
                if (held == 0) begin
                    reqAddr = core_if.addr;
                    reqLen = core_if.len;
                    stable = 1'b1;
                end else if (core_if.addr !== reqAddr || core_if.len !== reqLen) begin
                    stable = 1'b0;
                end
                held++;
                if (held > acceptDelay) begin
                    core_if.accept = 1'b1;
                    gotAddr.push_back(reqAddr);
                    gotLen.push_back(int'(reqLen));
                    gotHeld.push_back(held);
                    gotStable.push_back(stable);
                    held = 0;
                    beat = 0;
                    @(negedge clk);
                    core_if.accept = 1'b0;
                    while (beat < int'(reqLen) && !rst) begin
                        if (ackGaps && $urandom_range(0, 2) == 0) begin
                            @(negedge clk);
                            continue;
                        end
                        if (beat == errBeat) begin
                            core_if.error = 1'b1;
                            @(negedge clk);
                            core_if.error = 1'b0;
                            break;
                        end
                        core_if.ack = 1'b1;
                        core_if.read_data = memWord(reqAddr + ADDR_W'(beat));
                        beat++;
                        @(negedge clk);
                        core_if.ack = 1'b0;
                    end
                end
            end
        end
    end

    // Stream monitor: pops, done pulses and request cycles
    initial begin : p_mon
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (m_valid && m_ready) gotData.push_back(m_data);
                if (done) doneCnt++;
                if (core_if.rd) rdCycles++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Job-level model: bursts of min(BURST_LEN, remaining), words in address order
    task automatic buildModel(input logic [ADDR_W-1:0] base, input int total);
        int off;
        int n;
        expAddr.delete(); expLen.delete(); expData.delete();
        gotAddr.delete(); gotLen.delete(); gotHeld.delete(); gotStable.delete();
        gotData.delete();
        doneCnt = 0;
        rdCycles = 0;
        off = 0;
        while (off < total) begin
            n = (total - off < BURST_LEN) ? total - off : BURST_LEN;
            expAddr.push_back(base + ADDR_W'(off));
            expLen.push_back(n);
            off += n;
        end
        for (int i = 0; i < total; i++) expData.push_back(memWord(base + ADDR_W'(i)));
    endtask

    task automatic pulseStart(input logic [ADDR_W-1:0] base, input int total);
        base_addr = base;
        total_words = CNT_W'(total);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Drain until the job ends and every expected word is out, then compare
    task automatic finishJob(input string tag, input bit rndReady);
        int cyc;
        cyc = 0;
        while ((busy || gotData.size() < expData.size()) && cyc < 4000) begin
            m_ready = rndReady ? ($urandom_range(0, 3) != 0) : 1'b1;
            tick();
            cyc++;
        end
        m_ready = 1'b0;
        chk({tag, " timeout"}, 32'(cyc < 4000), 32'd1);
        chk({tag, " done pulses"}, 32'(doneCnt), 32'd1);
        chk({tag, " request count"}, 32'(gotAddr.size()), 32'(expAddr.size()));
        for (int i = 0; i < expAddr.size() && i < gotAddr.size(); i++) begin
            chk({tag, " req addr"}, 32'(gotAddr[i]), 32'(expAddr[i]));
            chk({tag, " req len"}, 32'(gotLen[i]), 32'(expLen[i]));
        end
        chk({tag, " word count"}, 32'(gotData.size()), 32'(expData.size()));
        for (int i = 0; i < expData.size() && i < gotData.size(); i++) begin
            chk({tag, " word"}, 32'(gotData[i]), 32'(expData[i]));
        end
    endtask

    initial begin : p_main
        int cyc;
        logic [ADDR_W-1:0] rb;

        // Reset state
        repeat (3) tick();
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst error", 32'(error), 32'd0);
        chk("rst m_valid", 32'(m_valid), 32'd0);
        chk("rst m_data", 32'(m_data), 32'd0);
        chk("rst rd", 32'(core_if.rd), 32'd0);
        chk("rst wr", 32'(core_if.wr), 32'd0);
        chk("rst addr", 32'(core_if.addr), 32'd0);
        chk("rst len", 32'(core_if.len), 32'd0);
        chk("rst wdata", 32'(core_if.write_data), 32'd0);
        rst = 1'b0;
        tick();

        // Three bursts, first request two cycles after start
        buildModel(24'h000100, 20);
        m_ready = 1'b1;
        pulseStart(24'h000100, 20);
        chk("t1 busy", 32'(busy), 32'd1);
        chk("t1 rd early", 32'(core_if.rd), 32'd0);
        tick();
        chk("t1 rd latency", 32'(core_if.rd), 32'd1);
        chk("t1 addr", 32'(core_if.addr), 32'h100);
        chk("t1 len", 32'(core_if.len), 32'd8);
        finishJob("t1", 1'b0);

        // Back-pressure: only FIFO_DEPTH words requested until space frees up
        buildModel(24'h002000, 32);
        m_ready = 1'b0;
        pulseStart(24'h002000, 32);
        repeat (80) tick();
        chk("t2 reqs stalled", 32'(gotAddr.size()), 32'd2);
        chk("t2 rd idle", 32'(core_if.rd), 32'd0);
        chk("t2 m_valid", 32'(m_valid), 32'd1);
        m_ready = 1'b1;
        repeat (8) tick();
        m_ready = 1'b0;
        chk("t2 pops", 32'(gotData.size()), 32'd8);
        cyc = 0;
        while (gotAddr.size() < 3 && cyc < 40) begin tick(); cyc++; end
        chk("t2 third req", 32'(gotAddr.size()), 32'd3);
        finishJob("t2", 1'b0);

        // Zero-length job
        buildModel(24'h000300, 0);
        pulseStart(24'h000300, 0);
        chk("t3 done", 32'(done), 32'd1);
        tick();
        chk("t3 done end", 32'(done), 32'd0);
        chk("t3 busy end", 32'(busy), 32'd0);
        repeat (3) tick();
        chk("t3 no rd", 32'(rdCycles), 32'd0);
        chk("t3 done pulses", 32'(doneCnt), 32'd1);

        // Slow accept: request held stable for six cycles
        acceptDelay = 5;
        rb = ADDR_W'($urandom);
        buildModel(rb, 8);
        pulseStart(rb, 8);
        finishJob("t4", 1'b0);
        chk("t4 held cycles", 32'(gotHeld[0]), 32'd6);
        chk("t4 stable", 32'(gotStable[0]), 32'd1);

        // Abort while the request waits for accept
        acceptDelay = 1000;
        buildModel(rb, 8);
        pulseStart(rb, 8);
        cyc = 0;
        while (!core_if.rd && cyc < 10) begin tick(); cyc++; end
        chk("t4b rd up", 32'(core_if.rd), 32'd1);
        tick();
        tick();
        abort = 1'b1;
        tick();
        chk("t4b rd drop", 32'(core_if.rd), 32'd0);
        chk("t4b done", 32'(done), 32'd1);
        abort = 1'b0;
        tick();
        chk("t4b busy", 32'(busy), 32'd0);
        chk("t4b no accept", 32'(gotAddr.size()), 32'd0);
        chk("t4b fifo empty", 32'(m_valid), 32'd0);
        acceptDelay = 0;

        // Core error on the third beat
        errBeat = 2;
        rb = ADDR_W'($urandom);
        buildModel(rb, 8);
        m_ready = 1'b0;
        pulseStart(rb, 8);
        cyc = 0;
        while (doneCnt == 0 && cyc < 40) begin tick(); cyc++; end
        chk("t5 done pulses", 32'(doneCnt), 32'd1);
        chk("t5 error", 32'(error), 32'd1);
        tick();
        chk("t5 busy", 32'(busy), 32'd0);
        m_ready = 1'b1;
        repeat (4) tick();
        m_ready = 1'b0;
        chk("t5 partial words", 32'(gotData.size()), 32'd2);
        chk("t5 word0", 32'(gotData[0]), 32'(expData[0]));
        chk("t5 word1", 32'(gotData[1]), 32'(expData[1]));
        errBeat = -1;
        buildModel(rb + 24'd64, 4);
        pulseStart(rb + 24'd64, 4);
        chk("t5 error cleared", 32'(error), 32'd0);
        finishJob("t5b", 1'b0);

        // Address wrap at the top of the space
        buildModel(24'hFFFFF8, 16);
        pulseStart(24'hFFFFF8, 16);
        finishJob("t6", 1'b0);
        chk("t6 wrap addr", 32'(gotAddr[1]), 32'h000000);

        // Reset in the middle of a burst
        buildModel(24'h000500, 16);
        m_ready = 1'b0;
        pulseStart(24'h000500, 16);
        cyc = 0;
        while (!m_valid && cyc < 20) begin tick(); cyc++; end
        chk("t6b in data", 32'(m_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6b busy", 32'(busy), 32'd0);
        chk("t6b rd", 32'(core_if.rd), 32'd0);
        chk("t6b m_valid", 32'(m_valid), 32'd0);
        chk("t6b m_data", 32'(m_data), 32'd0);
        chk("t6b done", 32'(done), 32'd0);
        tick();
        rst = 1'b0;
        repeat (2) tick();

        // Randomized jobs with gappy acks, variable accept and random back-pressure
        ackGaps = 1'b1;
        for (int j = 0; j < 6; j++) begin
            int tot;
            acceptDelay = $urandom_range(0, 3);
            rb = ADDR_W'($urandom);
            tot = $urandom_range(1, 40);
            buildModel(rb, tot);
            pulseStart(rb, tot);
            finishJob("rand", 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
`default_nettype wire
